// File: rtl/conv3x3_rgb_mac.sv
// 27-term RGB 3x3 MAC with bias, round-half-up and saturation; 3 cycles (5 with CONV_HSWISH_EN h-swish).
// One window per cycle, no backpressure; windows arriving before all 28 weights are written are dropped and counted.
module conv3x3_rgb_mac #(
   parameter int bitsize = 18,
   parameter int FRAC    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_valid,
   input  logic [bitsize*9-1:0]   window_r,
   input  logic [bitsize*9-1:0]   window_g,
   input  logic [bitsize*9-1:0]   window_b,
   input  logic                   wt_wr_en,
   input  logic [4:0]             wt_addr,
   input  logic [bitsize-1:0]     wt_data,
   output logic                   weights_ready,
   output logic [bitsize-1:0]     out_pixel,
   output logic                   out_valid,
   output logic [15:0]            drop_cnt
);
   localparam int PW = 2*bitsize;
   localparam int SW = 2*bitsize + 4;
   localparam int TW = 2*bitsize + 6;
   localparam logic signed [TW-1:0] RND  = TW'(1) <<< (FRAC-1);
   localparam logic signed [TW-1:0] PMAX = TW'((64'sd1 <<< (bitsize-1)) - 64'sd1);
   localparam logic signed [TW-1:0] PMIN = ~PMAX;

   function automatic logic [bitsize-1:0] sat(input logic signed [TW-1:0] v);
      if (v > PMAX) return PMAX[bitsize-1:0];
      if (v < PMIN) return PMIN[bitsize-1:0];
      return v[bitsize-1:0];
   endfunction

   logic signed [bitsize-1:0] wt [27];
   logic signed [bitsize-1:0] bias;
   logic [27:0]               mask;
   logic                      accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 27; i++) wt[i] <= '0;
         bias <= '0;
         mask <= '0;
      end else if (wt_wr_en && wt_addr <= 5'd27) begin
         if (wt_addr == 5'd27) bias <= wt_data;
         else                  wt[wt_addr] <= wt_data;
         mask[wt_addr] <= 1'b1;
      end
   end

   assign weights_ready = &mask;
   assign accept        = data_valid & weights_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         drop_cnt <= '0;
      else if (data_valid && !weights_ready && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end

   logic signed [bitsize-1:0] pix [27];
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         pix[k]      = window_r[bitsize*k +: bitsize];
         pix[k + 9]  = window_g[bitsize*k +: bitsize];
         pix[k + 18] = window_b[bitsize*k +: bitsize];
      end
   end

   // Stage 1: products and bias are captured together so later writes cannot touch this window.
   logic signed [PW-1:0]      prod [27];
   logic signed [bitsize-1:0] s1_bias;
   logic                      s1_vld;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 27; i++) prod[i] <= '0;
         s1_bias <= '0;
         s1_vld  <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            for (int i = 0; i < 27; i++) prod[i] <= PW'(pix[i]) * PW'(wt[i]);
            s1_bias <= bias;
         end
      end
   end

   logic signed [SW-1:0]      csum   [3];
   logic signed [SW-1:0]      s2_sum [3];
   logic signed [bitsize-1:0] s2_bias;
   logic                      s2_vld;
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         csum[c] = '0;
         for (int j = 0; j < 9; j++) csum[c] = csum[c] + SW'(prod[c*9 + j]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < 3; c++) s2_sum[c] <= '0;
         s2_bias <= '0;
         s2_vld  <= 1'b0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            for (int c = 0; c < 3; c++) s2_sum[c] <= csum[c];
            s2_bias <= s1_bias;
         end
      end
   end

   logic signed [TW-1:0]      total, shr;
   logic signed [bitsize-1:0] s3_pix;
   logic                      s3_vld;
   always_comb begin
      total = TW'(s2_sum[0]) + TW'(s2_sum[1]) + TW'(s2_sum[2]) + (TW'(s2_bias) <<< FRAC) + RND;
      shr   = total >>> FRAC;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_pix <= '0;
         s3_vld <= 1'b0;
      end else begin
         s3_vld <= s2_vld;
         if (s2_vld) s3_pix <= sat(shr);
      end
   end

`ifdef CONV_HSWISH_EN
   localparam int QW = PW + 16;
   localparam logic signed [bitsize+1:0] THREE = (bitsize+2)'(3 <<< FRAC);
   localparam logic signed [bitsize+1:0] SIX   = (bitsize+2)'(6 <<< FRAC);
   localparam logic signed [QW-1:0]      HRND  = QW'(64'sd1 <<< (FRAC+15));

   logic signed [bitsize+1:0] xp3, tcl;
   logic signed [PW-1:0]      s4_p;
   logic                      s4_vld;
   logic signed [QW-1:0]      q, ysh;
   logic signed [bitsize-1:0] s5_pix;
   logic                      s5_vld;

   always_comb begin
      xp3 = (bitsize+2)'(s3_pix) + THREE;
      if (xp3 < 0)        tcl = '0;
      else if (xp3 > SIX) tcl = SIX;
      else                tcl = xp3;
      // 10923 ~= 2^16/6, so the extra 16-bit shift completes the divide by six.
      q   = QW'(s4_p) * QW'(10923) + HRND;
      ysh = q >>> (FRAC + 16);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s4_p   <= '0;
         s4_vld <= 1'b0;
         s5_pix <= '0;
         s5_vld <= 1'b0;
      end else begin
         s4_vld <= s3_vld;
         s5_vld <= s4_vld;
         if (s3_vld) s4_p   <= PW'(s3_pix) * PW'(tcl);
         if (s4_vld) s5_pix <= sat(TW'(ysh));
      end
   end

   assign out_pixel = s5_pix;
   assign out_valid = s5_vld;
`else
   assign out_pixel = s3_pix;
   assign out_valid = s3_vld;
`endif

endmodule

// File: tb/tb_conv3x3_rgb_mac.sv
// Scoreboard bench for conv3x3_rgb_mac: expected pixel and arrival cycle queued at drive time.
module tb_conv3x3_rgb_mac;
   localparam int BS   = 18;
   localparam int FRAC = 10;
`ifdef CONV_HSWISH_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   typedef int win_t [9];
   typedef struct { longint val; int cyc; } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              data_valid;
   logic [BS*9-1:0]   window_r, window_g, window_b;
   logic              wt_wr_en;
   logic [4:0]        wt_addr;
   logic [BS-1:0]     wt_data;
   logic              weights_ready;
   logic [BS-1:0]     out_pixel;
   logic              out_valid;
   logic [15:0]       drop_cnt;

   conv3x3_rgb_mac #(.bitsize(BS), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid),
      .window_r(window_r), .window_g(window_g), .window_b(window_b),
      .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .weights_ready(weights_ready), .out_pixel(out_pixel),
      .out_valid(out_valid), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int     cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     n_out = 0;
   exp_t   sbq [$];
   longint wmod [28];
   bit [27:0] mmod;
   bit     ready_model;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint sat(input longint v);
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   function automatic longint hswish(input longint x);
      longint t, p, y;
      t = x + 3072;
      if (t < 0)    t = 0;
      if (t > 6144) t = 6144;
      p = x * t;
      y = (p * 10923 + (64'sd1 <<< 25)) >>> 26;
      return sat(y);
   endfunction

   function automatic longint post(input longint lin);
`ifdef CONV_HSWISH_EN
      return hswish(lin);
`else
      return lin;
`endif
   endfunction

   function automatic longint lin_model(input win_t r, input win_t g, input win_t b);
      longint acc;
      acc = 0;
      for (int k = 0; k < 9; k++)
         acc += longint'(r[k]) * wmod[k] + longint'(g[k]) * wmod[k+9] + longint'(b[k]) * wmod[k+18];
      acc += wmod[27] * 1024;
      acc = (acc + 512) >>> FRAC;
      return sat(acc);
   endfunction

   function automatic logic [BS*9-1:0] pack(input win_t w);
      logic [BS*9-1:0] p;
      p = '0;
      for (int k = 0; k < 9; k++) p[BS*k +: BS] = BS'(w[k]);
      return p;
   endfunction

   task automatic wr(input int a, input longint d);
      @(negedge clk);
      wt_wr_en = 1'b1;
      wt_addr  = a[4:0];
      wt_data  = d[BS-1:0];
      @(posedge clk);
      #1 wt_wr_en = 1'b0;
      if (a <= 27) begin
         wmod[a] = d;
         mmod[a] = 1'b1;
         ready_model = &mmod;
      end
   endtask

   task automatic send(input win_t r, input win_t g, input win_t b, input longint lin_exp);
      exp_t e;
      @(negedge clk);
      data_valid = 1'b1;
      window_r = pack(r);
      window_g = pack(g);
      window_b = pack(b);
      if (ready_model) begin
         e.val = post(lin_exp);
         e.cyc = cyc + LAT;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) check("drain_timeout", sbq.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid) begin
         exp_t e;
         n_out++;
         if (sbq.size() == 0) check("unexpected_out", 1, 0);
         else begin
            e = sbq.pop_front();
            check("pixel", longint'($signed(out_pixel)), e.val);
            check("latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      win_t z, r, g, b;
      z = '{default: 0};
      for (int i = 0; i < 28; i++) wmod[i] = 0;
      mmod = '0;
      ready_model = 1'b0;
      rst = 1'b0;
      data_valid = 1'b0;
      window_r = '0; window_g = '0; window_b = '0;
      wt_wr_en = 1'b0; wt_addr = '0; wt_data = '0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_pixel", longint'(out_pixel), 0);
      check("rst_drop_cnt", longint'(drop_cnt), 0);
      check("rst_ready", longint'(weights_ready), 0);
      rst = 1'b1;

      // Windows before any weights are written are dropped.
      send(z, z, z, 0);
      send(z, z, z, 0);
      @(negedge clk);
      check("drop_cnt", longint'(drop_cnt), 2);
      check("ready_before_wr", longint'(weights_ready), 0);

      for (int a = 0; a < 27; a++) wr(a, (a == 4) ? 1024 : 0);
      check("ready_27_writes", longint'(weights_ready), 0);
      wr(27, 512);
      check("ready_28_writes", longint'(weights_ready), 1);
      r = z; r[4] = 2048;
      send(r, z, z, 2560);
      drain();

      for (int a = 0; a < 27; a++) wr(a, 1024);
      wr(27, 0);
      r = '{default: 4096};
      send(r, r, r, 110592);
      r = '{default: 8192};
      send(r, r, r, 131071);
      r = '{default: -8192};
      send(r, r, r, -131072);
      drain();

      for (int a = 0; a < 27; a++) wr(a, (a == 4) ? 512 : 0);
      r = z; r[4] = 3;
      send(r, z, z, 2);
      r[4] = -3;
      send(r, z, z, -1);
      drain();

      for (int a = 0; a < 28; a++) wr(a, longint'(int'($urandom_range(2047, 0)) - 1024));
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 9; k++) begin
            r[k] = int'($urandom_range(8191, 0)) - 4096;
            g[k] = int'($urandom_range(8191, 0)) - 4096;
            b[k] = int'($urandom_range(8191, 0)) - 4096;
         end
         send(r, g, b, lin_model(r, g, b));
      end
      drain();

      // Reset with windows in flight: nothing may emerge afterwards.
      for (int n = 0; n < 3; n++) begin
         for (int k = 0; k < 9; k++) r[k] = int'($urandom_range(4095, 0)) - 2048;
         send(r, r, r, lin_model(r, r, r));
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_ready", longint'(weights_ready), 0);
      check("midrst_drop_cnt", longint'(drop_cnt), 0);
      sbq.delete();
      for (int i = 0; i < 28; i++) wmod[i] = 0;
      mmod = '0;
      ready_model = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      n_out = 0;
      repeat (10) @(negedge clk);
      check("no_out_after_rst", n_out, 0);

      for (int a = 0; a < 28; a++) wr(a, (a == 4) ? 1024 : 0);
      r = z; r[4] = 1024;
      send(r, z, z, 1024);
      r[4] = 4096;
      send(r, z, z, 4096);
      r[4] = -4096;
      send(r, z, z, -4096);
      drain();
      check("final_ready", longint'(weights_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv3x3_rgb_mac.md
Name: conv3x3_rgb_mac

Overview:
- Stage directly downstream of the RGB 3x3 window FIFO.
- Consumes one 3x3 window per channel (R, G, B) per valid cycle and computes one output-channel pixel: the 27-term signed fixed-point dot product with a loaded kernel, plus bias, rounded and saturated back to pixel width.
- Fully pipelined: one window accepted per cycle. Kernel and bias are loaded through a small register-write port before or between frames.

Parameters:
- bitsize, 18, signed pixel/weight/bias width
- FRAC, 10, fractional bits of the Q format shared by pixels, weights, bias and output

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- data_valid  in  1  window inputs valid this cycle
- window_r  in  bitsize*9  R window; element k=row*3+col at bits [bitsize*k+bitsize-1 : bitsize*k], k=0 is top-left
- window_g  in  bitsize*9  G window, same packing
- window_b  in  bitsize*9  B window, same packing
- wt_wr_en  in  1  weight/bias write strobe
- wt_addr  in  5  0-8 R, 9-17 G, 18-26 B (addr mod 9 = k), 27 bias, 28-31 ignored
- wt_data  in  bitsize  signed weight/bias value
- weights_ready  out  1  all 28 locations written since reset
- out_pixel  out  bitsize  signed result
- out_valid  out  1  out_pixel valid
- drop_cnt  out  16  windows discarded because weights_ready was 0; saturates at 65535

Behaviour:
- Reset (rst=0, async): all weights and bias cleared to 0; written-mask cleared; weights_ready=0; out_pixel=0; out_valid=0; drop_cnt=0; all pipeline valid bits cleared, so in-flight windows are discarded.
- Weight write: on a clk edge with wt_wr_en=1 and wt_addr<=27, the location takes wt_data and its mask bit is set. weights_ready=1 from the cycle after the last of the 28 mask bits is set, then stays 1 until reset.
- A write takes effect for windows accepted on later edges. A window already accepted keeps the weights it captured at acceptance.
- Accept: data_valid=1 and weights_ready=1. Otherwise data_valid=1 increments drop_cnt (saturating) and the window is discarded.
- Stage 1 (accept edge): 27 signed products bitsize x bitsize -> 2*bitsize bits, Q(2*FRAC), registered.
- Stage 2: three per-channel 9-term sums, each 2*bitsize+4 bits, registered.
- Stage 3: total = sum of the three channel sums + (bias <<< FRAC), 2*bitsize+6 bits. Round half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC. Saturate to [-2^(bitsize-1), 2^(bitsize-1)-1]. Register into out_pixel and set out_valid.
- Latency: 3 cycles from accept edge to out_valid.
- Throughput: 1 window/cycle; back-to-back windows give back-to-back outputs.
- out_valid is high for exactly one cycle per accepted window.
- out_pixel holds its last value when out_valid=0.
- No backpressure: the downstream stage must accept every out_valid.

Optional Feature:
- Macro CONV_HSWISH_EN.
- When defined, h-swish is applied after stage 3:
  - Stage 4: t = clamp(x + 3.0, 0, 6.0); p = x*t, 2*bitsize bits, Q(2*FRAC).
  - Stage 5: y = round_half_up((p * 10923) >>> (FRAC+16)), where 10923 = round(2^16/6). Saturate y to bitsize, then register.
  - Latency becomes 5 cycles.
- When undefined, the output is linear and latency is 3 cycles.
- All other behaviour is identical either way.

Test Plan:
- data_valid=1 for 2 cycles before any weight write -> out_valid stays 0, drop_cnt=2, weights_ready=0.
- Write addr 0-26 = 0 except addr 4 = 1024 (1.0), bias = 512. Then 27 writes zero -> weights_ready=0. After the addr-27 write -> weights_ready=1. Window R center = 2048, others 0 -> out_pixel=2560, out_valid exactly 3 cycles later (linear build).
- All weights 1024, bias 0, all pixels 4096 -> 110592. All pixels 8192 -> 131071 (saturated). All pixels -8192 -> -131072.
- Rounding: addr 4 = 512, R center = 3 -> 2. R center = -3 -> -1.
- Five back-to-back windows with different values -> five consecutive out_valid cycles, in order. Assert rst mid-stream -> out_valid=0 immediately, nothing emitted afterwards, weights_ready=0.
- CONV_HSWISH_EN, center weight 1.0, bias 0:
  - x = 1024 -> 683, latency 5.
  - x = 4096 -> 4096.
  - x = -4096 -> 0.
